lsu_axi_gen: RTL and testbench

- Parametrised load/store unit between the execute stage and a single AXI4-Lite-style memory master port.
- Accepts one memory request at a time from the pipeline over a valid/ready handshake and drives full AW/W/B or AR/R handshakes.
- Holds every bus valid until it is accepted, aligns and masks data by access size and signedness, and returns a handshaked writeback response.
- Adds two things the previous LSU lacked: width genericity and misaligned-access fault detection.

---
 rtl/lsu_pkg.sv | 7 +
 rtl/lsu_lane_align.sv | 35 +++
 rtl/lsu_axi_gen.sv | 131 +++++++++++++
 tb/tb_lsu_axi_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state, size, error and bus response codes for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;
  localparam logic [1:0] ERR_OK = 2'b00, ERR_BUS = 2'b10, ERR_MISALIGN = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane shift/strobe, load extract/extend and alignment check
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]      off,
  input  logic [1:0]            size,
  input  logic                  sgn,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] st_data,
  output logic [STRB_W-1:0]     st_strb,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  misalign
);
  logic [STRB_W-1:0] bmask;
  logic [OFF_W-1:0] amask;
  logic [DATA_WIDTH-1:0] dmask, sh;
  logic sb;
  assign bmask = ~({STRB_W{1'b1}} << (4'd1 << size));
  assign amask = ~({OFF_W{1'b1}} << size);
  assign misalign = (size == SZ_D && OFF_W < 3) || |(off & amask);
  assign st_data = wdata << {off, 3'b000};
  assign st_strb = bmask << off;
  assign sh = rdata >> {off, 3'b000};
  for (genvar g = 0; g < STRB_W; g++) begin : g_mask
    assign dmask[8*g +: 8] = {8{bmask[g]}};
  end
  // a full-width access has an all-ones mask, so no extension bits are added
  assign sb = size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : sh[DATA_WIDTH-1];
  assign ld_data = (sh & dmask) | ({DATA_WIDTH{sgn & sb}} & ~dmask);
endmodule

// File: rtl/lsu_axi_gen.sv
// lsu_axi_gen: single-outstanding load/store unit driving an AXI4-Lite style master port
module lsu_axi_gen
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int REG_AW = 5,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(STRB_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [REG_AW-1:0]     req_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_wen,
  output logic [REG_AW-1:0]     rsp_rd,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_err,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_W-1:0]     w_strb,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_resp,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp
);
  state_t state, state_n;
  logic sgn_q, aw_done, w_done, wen_q, misalign, idle, aw_fire, w_fire;
  logic [1:0] size_q, err_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, data_q, st_data, ld_data;
  logic [STRB_W-1:0] st_strb;
  logic [REG_AW-1:0] rd_q;
  assign idle = state == IDLE;
  // in IDLE the live request feeds the alignment check; afterwards the latched one
  lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .off     (idle ? req_addr[OFF_W-1:0] : addr_q[OFF_W-1:0]),
    .size    (idle ? req_size : size_q),
    .sgn     (sgn_q),
    .wdata   (wdata_q),
    .rdata   (r_data),
    .st_data (st_data),
    .st_strb (st_strb),
    .ld_data (ld_data),
    .misalign(misalign)
  );
  always_comb begin
    req_ready = idle && !rst;
    aw_valid = state == WRITE && !aw_done;
    w_valid = state == WRITE && !w_done;
    aw_fire = aw_valid && aw_ready;
    w_fire = w_valid && w_ready;
    aw_addr = aw_valid ? addr_q : '0;
    w_data = w_valid ? st_data : '0;
    w_strb = w_valid ? st_strb : '0;
    b_ready = state == WRESP;
    ar_valid = state == RADDR;
    ar_addr = ar_valid ? addr_q : '0;
    r_ready = state == RDATA;
    rsp_valid = state == RESP;
    rsp_wen = rsp_valid && wen_q;
    rsp_rd = rsp_valid ? rd_q : '0;
    rsp_data = rsp_valid ? data_q : '0;
    rsp_err = rsp_valid ? err_q : ERR_OK;
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = misalign ? RESP : req_we ? WRITE : RADDR;
      WRITE:   if ((aw_done || aw_fire) && (w_done || w_fire)) state_n = WRESP;
      WRESP:   if (b_valid) state_n = RESP;
      RADDR:   if (ar_ready) state_n = RDATA;
      RDATA:   if (r_valid) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sgn_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      err_q <= ERR_OK;
      wen_q <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_n;
      if (idle && req_valid) begin
        size_q <= req_size;
        sgn_q <= req_signed;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        rd_q <= req_rd;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        err_q <= misalign ? ERR_MISALIGN : ERR_OK;
        wen_q <= 1'b0;
        data_q <= '0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire) w_done <= 1'b1;
      if (b_ready && b_valid) err_q <= b_resp != RESP_OKAY ? ERR_BUS : ERR_OK;
      if (r_ready && r_valid) begin
        err_q <= r_resp != RESP_OKAY ? ERR_BUS : ERR_OK;
        wen_q <= r_resp == RESP_OKAY;
        data_q <= r_resp == RESP_OKAY ? ld_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_lsu_axi_gen.sv
// tb_lsu_axi_gen: scoreboard bench running the same directed scenarios on 64- and 32-bit LSUs
module tb_lsu_axi_gen;
  typedef struct packed {logic wen; logic [4:0] rd; logic [63:0] data; logic [1:0] err;} rsp_t;
  typedef struct packed {logic [63:0] d; logic [7:0] s;} wexp_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, sel = 0, bus_cnt = 0;
  rsp_t rq[$];
  wexp_t wq[$];
  logic [63:0] awq[$];
  logic req_valid = 0, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic [4:0] req_rd = 0;
  int aw_lat = 0, ar_lat = 0, rsp_lat = 0;
  logic [1:0] b_resp_cfg = 0, r_resp_cfg = 0;
  logic [63:0] r_data_cfg = 0;
  logic aw_ready, w_ready, b_valid, ar_ready, r_valid, rsp_ready;
  logic [1:0] b_resp, r_resp;
  logic [63:0] r_data;
  logic req_valid_a, req_ready_a, rsp_valid_a, rsp_wen_a, aw_valid_a, w_valid_a, b_ready_a, ar_valid_a, r_ready_a;
  logic req_valid_b, req_ready_b, rsp_valid_b, rsp_wen_b, aw_valid_b, w_valid_b, b_ready_b, ar_valid_b, r_ready_b;
  logic [4:0] rsp_rd_a, rsp_rd_b;
  logic [1:0] rsp_err_a, rsp_err_b;
  logic [63:0] rsp_data_a, aw_addr_a, ar_addr_a, w_data_a, aw_addr_b, ar_addr_b;
  logic [31:0] rsp_data_b, w_data_b;
  logic [7:0] w_strb_a;
  logic [3:0] w_strb_b;
  assign req_valid_a = req_valid && sel == 0;
  assign req_valid_b = req_valid && sel == 1;
  lsu_axi_gen #(.DATA_WIDTH(64)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen_a),
    .rsp_rd(rsp_rd_a), .rsp_data(rsp_data_a), .rsp_err(rsp_err_a), .aw_valid(aw_valid_a),
    .aw_ready(aw_ready), .aw_addr(aw_addr_a), .w_valid(w_valid_a), .w_ready(w_ready),
    .w_data(w_data_a), .w_strb(w_strb_a), .b_valid(b_valid), .b_ready(b_ready_a), .b_resp(b_resp),
    .ar_valid(ar_valid_a), .ar_ready(ar_ready), .ar_addr(ar_addr_a), .r_valid(r_valid),
    .r_ready(r_ready_a), .r_data(r_data), .r_resp(r_resp));
  lsu_axi_gen #(.DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .req_rd(req_rd), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_wen(rsp_wen_b),
    .rsp_rd(rsp_rd_b), .rsp_data(rsp_data_b), .rsp_err(rsp_err_b), .aw_valid(aw_valid_b),
    .aw_ready(aw_ready), .aw_addr(aw_addr_b), .w_valid(w_valid_b), .w_ready(w_ready),
    .w_data(w_data_b), .w_strb(w_strb_b), .b_valid(b_valid), .b_ready(b_ready_b), .b_resp(b_resp),
    .ar_valid(ar_valid_b), .ar_ready(ar_ready), .ar_addr(ar_addr_b), .r_valid(r_valid),
    .r_ready(r_ready_b), .r_data(r_data[31:0]), .r_resp(r_resp));
  logic v_req_ready, v_rsp_valid, v_rsp_wen, v_aw_valid, v_w_valid, v_b_ready, v_ar_valid, v_r_ready;
  logic [4:0] v_rsp_rd;
  logic [1:0] v_rsp_err;
  logic [63:0] v_rsp_data, v_aw_addr, v_ar_addr, v_w_data;
  logic [7:0] v_w_strb;
  assign v_req_ready = sel == 1 ? req_ready_b : req_ready_a;
  assign v_rsp_valid = sel == 1 ? rsp_valid_b : rsp_valid_a;
  assign v_rsp_wen = sel == 1 ? rsp_wen_b : rsp_wen_a;
  assign v_rsp_rd = sel == 1 ? rsp_rd_b : rsp_rd_a;
  assign v_rsp_err = sel == 1 ? rsp_err_b : rsp_err_a;
  assign v_rsp_data = sel == 1 ? {32'b0, rsp_data_b} : rsp_data_a;
  assign v_aw_valid = sel == 1 ? aw_valid_b : aw_valid_a;
  assign v_aw_addr = sel == 1 ? aw_addr_b : aw_addr_a;
  assign v_w_valid = sel == 1 ? w_valid_b : w_valid_a;
  assign v_w_data = sel == 1 ? {32'b0, w_data_b} : w_data_a;
  assign v_w_strb = sel == 1 ? {4'b0, w_strb_b} : w_strb_a;
  assign v_b_ready = sel == 1 ? b_ready_b : b_ready_a;
  assign v_ar_valid = sel == 1 ? ar_valid_b : ar_valid_a;
  assign v_ar_addr = sel == 1 ? ar_addr_b : ar_addr_a;
  assign v_r_ready = sel == 1 ? r_ready_b : r_ready_a;
  // slave model: configurable AW/AR/rsp stalls, B and R one cycle after address/data
  int aw_cnt, ar_cnt, rsp_cnt;
  logic aw_seen, w_seen, r_pend;
  assign aw_ready = v_aw_valid && aw_cnt >= aw_lat;
  assign w_ready = v_w_valid;
  assign b_valid = aw_seen && w_seen;
  assign b_resp = b_valid ? b_resp_cfg : 2'b00;
  assign ar_ready = v_ar_valid && ar_cnt >= ar_lat;
  assign r_valid = r_pend;
  assign r_data = r_pend ? r_data_cfg : 64'h0;
  assign r_resp = r_pend ? r_resp_cfg : 2'b00;
  assign rsp_ready = v_rsp_valid && rsp_cnt >= rsp_lat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; ar_cnt <= 0; rsp_cnt <= 0;
      aw_seen <= 0; w_seen <= 0; r_pend <= 0;
    end else begin
      aw_cnt <= (v_aw_valid && !aw_ready) ? aw_cnt + 1 : 0;
      ar_cnt <= (v_ar_valid && !ar_ready) ? ar_cnt + 1 : 0;
      rsp_cnt <= (v_rsp_valid && !rsp_ready) ? rsp_cnt + 1 : 0;
      if (v_aw_valid && aw_ready) aw_seen <= 1;
      if (v_w_valid && w_ready) w_seen <= 1;
      if (b_valid && v_b_ready) begin aw_seen <= 0; w_seen <= 0; end
      if (v_ar_valid && ar_ready) r_pend <= 1;
      else if (r_pend && v_r_ready) r_pend <= 0;
    end
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic fail(input string n);
    total++;
    bad++;
    $display("FAIL %s: event not expected", n);
  endtask
  // monitor: bus channels, protocol holds and the response scoreboard
  logic aw_stall_q, ar_stall_q;
  logic [63:0] aw_addr_q, ar_addr_q;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      aw_stall_q <= 0; ar_stall_q <= 0;
    end else begin
      if (v_aw_valid || v_w_valid || v_ar_valid) bus_cnt <= bus_cnt + 1;
      if (aw_stall_q) begin chk("aw_hold", v_aw_valid, 1); chk("aw_addr_hold", v_aw_addr, aw_addr_q); end
      if (ar_stall_q) begin chk("ar_hold", v_ar_valid, 1); chk("ar_addr_hold", v_ar_addr, ar_addr_q); end
      aw_stall_q <= v_aw_valid && !aw_ready;
      ar_stall_q <= v_ar_valid && !ar_ready;
      aw_addr_q <= v_aw_addr;
      ar_addr_q <= v_ar_addr;
      if (w_seen) chk("w_dropped", v_w_valid, 0);
      if (aw_seen) chk("aw_dropped", v_aw_valid, 0);
      if (v_b_ready) chk("b_after_both", aw_seen && w_seen, 1);
      if (v_aw_valid && aw_ready) begin
        if (awq.size() == 0) fail("aw_unexpected");
        else chk("aw_addr", v_aw_addr, awq.pop_front());
      end
      if (v_w_valid && w_ready) begin
        if (wq.size() == 0) fail("w_unexpected");
        else begin
          chk("w_data", v_w_data, wq[0].d);
          chk("w_strb", v_w_strb, wq[0].s);
          void'(wq.pop_front());
        end
      end
      if (v_rsp_valid) begin
        chk("req_ready_in_resp", v_req_ready, 0);
        if (rq.size() == 0) fail("rsp_unexpected");
        else begin
          chk("rsp_data", v_rsp_data, rq[0].data);
          chk("rsp_err", v_rsp_err, rq[0].err);
          chk("rsp_wen", v_rsp_wen, rq[0].wen);
          chk("rsp_rd", v_rsp_rd, rq[0].rd);
          if (rsp_ready) void'(rq.pop_front());
        end
      end
    end
  end
  task automatic go(input logic we, input logic [1:0] size, input logic sgn, input logic [63:0] addr,
                    input logic [63:0] wdata, input logic [4:0] rd, input logic [63:0] exp_w,
                    input logic [7:0] exp_s, input logic [63:0] exp_d, input logic [1:0] exp_e,
                    input int exp_lat, input string n);
    int lat;
    rsp_t r;
    r.wen = !we && exp_e == 2'b00;
    r.rd = rd;
    r.data = exp_d;
    r.err = exp_e;
    rq.push_back(r);
    if (we && exp_e != 2'b11) begin
      awq.push_back(addr);
      wq.push_back({exp_w, exp_s});
    end
    @(negedge clk);
    chk({n, "_req_ready"}, v_req_ready, 1);
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 1;
    while (!v_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({n, "_lat"}, lat, exp_lat);
    while (v_rsp_valid && lat < 80) begin @(posedge clk); #1; lat++; end
    if (v_rsp_valid) fail({n, "_rsp_stuck"});
  endtask
  task automatic run_all(input int s);
    int b0;
    sel = s;
    aw_lat = 0; ar_lat = 0; rsp_lat = 0; b_resp_cfg = 0; r_resp_cfg = 0;
    go(1, 2, 0, 64'h8000_0004, 64'h1122_3344, 5'd1, s == 1 ? 64'h1122_3344 : 64'h1122_3344_0000_0000,
       s == 1 ? 8'h0F : 8'hF0, 0, 2'b00, 3, "sw");
    r_data_cfg = 64'h8000_0000;
    go(0, 0, 1, 64'h8000_0003, 0, 5'd5, 0, 0, s == 1 ? 64'hFFFF_FF80 : 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 3, "lb");
    go(0, 0, 0, 64'h8000_0003, 0, 5'd5, 0, 0, 64'h80, 2'b00, 3, "lbu");
    r_data_cfg = s == 1 ? 64'hBEEF_0000 : 64'hBEEF_0000_0000_0000;
    go(0, 1, 1, 64'h8000_0006, 0, 5'd9, 0, 0, s == 1 ? 64'hFFFF_BEEF : 64'hFFFF_FFFF_FFFF_BEEF, 2'b00, 3, "lh");
    r_data_cfg = s == 1 ? 64'hCAFE_F00D : 64'hDEAD_BEEF_CAFE_F00D;
    go(0, s == 1 ? 2'd2 : 2'd3, 1, 64'h8000_0008, 0, 5'd31, 0, 0, r_data_cfg, 2'b00, 3, "lfull");
    go(1, 0, 0, 64'h8000_0005, 64'hAB, 5'd2, s == 1 ? 64'hAB00 : 64'h0000_AB00_0000_0000,
       s == 1 ? 8'h02 : 8'h20, 0, 2'b00, 3, "sb");
    aw_lat = 4;
    go(1, 1, 0, 64'h8000_0002, 64'hBEEF, 5'd3, 64'hBEEF_0000, 8'h0C, 0, 2'b00, 7, "sh_awstall");
    aw_lat = 0;
    b0 = bus_cnt;
    go(0, 2, 0, 64'h8000_0002, 0, 5'd4, 0, 0, 0, 2'b11, 1, "lw_mis");
    chk("lw_mis_nobus", bus_cnt, b0);
    b0 = bus_cnt;
    go(1, 3, 0, s == 1 ? 64'h8000_0008 : 64'h8000_000C, 64'h55, 5'd6, 0, 0, 0, 2'b11, 1, "d_mis");
    chk("d_mis_nobus", bus_cnt, b0);
    r_resp_cfg = 2'b10; rsp_lat = 3; r_data_cfg = 64'h1234;
    go(0, 2, 0, 64'h8000_0000, 0, 5'd7, 0, 0, 0, 2'b10, 3, "lw_rerr");
    r_resp_cfg = 0; rsp_lat = 0; b_resp_cfg = 2'b11;
    go(1, 2, 0, 64'h8000_0010, 64'h77, 5'd8, 64'h77, 8'h0F, 0, 2'b10, 3, "sw_berr");
    b_resp_cfg = 0;
    ar_lat = 1000;
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2; req_addr = 64'h8000_0010; req_rd = 5'd7;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("rst_pre_arv", v_ar_valid, 1);
    chk("rst_pre_araddr", v_ar_addr, 64'h8000_0010);
    #1 rst = 1;
    #1;
    chk("rst_arv", v_ar_valid, 0);
    chk("rst_rspv", v_rsp_valid, 0);
    chk("rst_req_ready", v_req_ready, 0);
    @(posedge clk);
    #1 rst = 0;
    ar_lat = 0;
    r_data_cfg = s == 1 ? 64'h0BAD_F00D : 64'h0123_4567_89AB_CDEF;
    go(0, s == 1 ? 2'd2 : 2'd3, 0, 64'h8000_0010, 0, 5'd12, 0, 0, r_data_cfg, 2'b00, 3, "ld_after_rst");
  endtask
  initial begin
    #2;
    chk("reset_req_ready_a", req_ready_a, 0);
    chk("reset_req_ready_b", req_ready_b, 0);
    chk("reset_outs_a", {rsp_valid_a, aw_valid_a, w_valid_a, ar_valid_a, b_ready_a, r_ready_a}, 0);
    chk("reset_outs_b", {rsp_valid_b, aw_valid_b, w_valid_b, ar_valid_b, b_ready_b, r_ready_b}, 0);
    chk("reset_data_a", rsp_data_a | aw_addr_a | w_data_a, 0);
    @(posedge clk);
    #1 rst = 0;
    run_all(0);
    run_all(1);
    repeat (3) @(posedge clk);
    chk("rsp_q_empty", rq.size(), 0);
    chk("w_q_empty", wq.size() + awq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
